// File: rtl/mul_ctrl.sv
// mul_ctrl: PCPI sequencer for MUL/MULH/MULHSU/MULHU in front of the registered `mul` datapath.
// Optional feature macro MUL_CTRL_FUSE_EN replays the stored low half for a repeated MUL.

package m_ext_pkg;
    typedef enum logic [1:0] {
        RS1_RS2_UNSIGNED = 2'b00,
        RS1_SIGNED       = 2'b01,
        RS1_RS2_SIGNED   = 2'b10
    } op_sign_t;
endpackage

module mul_ctrl
    import m_ext_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pcpi_valid,
    input  logic [31:0]        pcpi_insn,
    input  logic [WIDTH-1:0]   pcpi_rs1,
    input  logic [WIDTH-1:0]   pcpi_rs2,
    output logic               pcpi_wr,
    output logic [WIDTH-1:0]   pcpi_rd,
    output logic               pcpi_wait,
    output logic               pcpi_ready,
    output logic [WIDTH-1:0]   mul_rs1,
    output logic [WIDTH-1:0]   mul_rs2,
    output op_sign_t           mul_operands_sign,
    input  logic [2*WIDTH-1:0] mul_res
);

    localparam logic [2:0] LAT = 3'(MUL_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       cnt, cnt_nxt;
    logic             hi_sel;
    logic             holdoff;
    logic [2:0]       funct3;
    logic             decode_hit;
    logic             accept;
    logic             fuse_hit;
    logic             use_cache;
    logic [WIDTH-1:0] cached_rd;
    op_sign_t         sign_dec;
    logic             unused_insn;

    assign funct3      = pcpi_insn[14:12];
    assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
    assign decode_hit  = pcpi_valid && (pcpi_insn[6:0] == 7'b0110011)
                         && (pcpi_insn[31:25] == 7'b0000001) && !pcpi_insn[14];
    // holdoff keeps a still-asserted valid from the finished instruction from re-entering
    assign accept      = (state == IDLE) && decode_hit && !holdoff;

    always_comb begin
        sign_dec = RS1_RS2_UNSIGNED;
        case (funct3[1:0])
            2'b01:   sign_dec = RS1_RS2_SIGNED;
            2'b10:   sign_dec = RS1_SIGNED;
            default: sign_dec = RS1_RS2_UNSIGNED;
        endcase
    end

`ifdef MUL_CTRL_FUSE_EN
    logic             cache_valid;
    logic             fused;
    logic [WIDTH-1:0] cache_rs1, cache_rs2, cache_lo;

    assign fuse_hit  = (funct3 == 3'b000) && cache_valid
                       && (pcpi_rs1 == cache_rs1) && (pcpi_rs2 == cache_rs2);
    assign use_cache = fused;
    assign cached_rd = cache_lo;

    // Low product half is sign-mode independent, so every full-path completion refills the cache
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            fused       <= 1'b0;
            cache_rs1   <= '0;
            cache_rs2   <= '0;
            cache_lo    <= '0;
        end else begin
            if (accept) begin
                fused <= fuse_hit;
            end
            if (state == DONE && !fused) begin
                cache_valid <= 1'b1;
                cache_rs1   <= mul_rs1;
                cache_rs2   <= mul_rs2;
                cache_lo    <= mul_res[WIDTH-1:0];
            end
        end
    end
`else
    assign fuse_hit  = 1'b0;
    assign use_cache = 1'b0;
    assign cached_rd = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            hi_sel            <= 1'b0;
            holdoff           <= 1'b0;
            mul_rs1           <= '0;
            mul_rs2           <= '0;
            mul_operands_sign <= RS1_RS2_UNSIGNED;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == DONE) begin
                holdoff <= 1'b1;
            end else if (!pcpi_valid) begin
                holdoff <= 1'b0;
            end
            if (accept && !fuse_hit) begin
                mul_rs1           <= pcpi_rs1;
                mul_rs2           <= pcpi_rs2;
                mul_operands_sign <= sign_dec;
                hi_sel            <= (funct3 != 3'b000);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        pcpi_wait  = (state != IDLE) || accept;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = fuse_hit ? DONE : EXEC;
                    cnt_nxt   = LAT;
                end
            end
            EXEC: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = 1'b1;
                if (use_cache) begin
                    pcpi_rd = cached_rd;
                end else if (hi_sel) begin
                    pcpi_rd = mul_res[2*WIDTH-1:WIDTH];
                end else begin
                    pcpi_rd = mul_res[WIDTH-1:0];
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
